// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the RV32I core with load-use hazard detection, flush and hold.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
`timescale 1ns/1ps

module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            id_valid,
  input  logic [2:0]      id_B_J,
  input  logic            id_memwrite_en,
  input  logic            id_regwrite_en,
  input  logic [3:0]      id_alu_op,
  input  logic [1:0]      id_data_size,
  input  logic            id_extension_type,
  input  logic [1:0]      id_wb_src,
  input  logic            id_alu_src,
  input  logic            id_op1_src,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_pc_plus4,

  input  logic            ex_flush,
  input  logic            mem_hold,

  output logic            ex_valid,
  output logic [2:0]      ex_B_J,
  output logic            ex_memwrite_en,
  output logic            ex_regwrite_en,
  output logic [3:0]      ex_alu_op,
  output logic [1:0]      ex_data_size,
  output logic            ex_extension_type,
  output logic [1:0]      ex_wb_src,
  output logic            ex_alu_src,
  output logic            ex_op1_src,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc_plus4,

  output logic            stall_if_id,
  output logic [PERF_W-1:0] bubble_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam logic [1:0] WB_MEM = 2'b01;

  typedef struct packed {
    logic            valid;
    logic [2:0]      b_j;
    logic            memwrite_en;
    logic            regwrite_en;
    logic [3:0]      alu_op;
    logic [1:0]      data_size;
    logic            extension_type;
    logic [1:0]      wb_src;
    logic            alu_src;
    logic            op1_src;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } stage_t;

  stage_t id_bundle;
  stage_t ex_q;
  stage_t ex_d;
  logic   load_use;
  logic   load_bubble;

  assign id_bundle = '{
    valid:          id_valid,
    b_j:            id_B_J,
    memwrite_en:    id_memwrite_en,
    regwrite_en:    id_regwrite_en,
    alu_op:         id_alu_op,
    data_size:      id_data_size,
    extension_type: id_extension_type,
    wb_src:         id_wb_src,
    alu_src:        id_alu_src,
    op1_src:        id_op1_src,
    rs1:            id_rs1,
    rs2:            id_rs2,
    rd:             id_rd,
    rs1_data:       id_rs1_data,
    rs2_data:       id_rs2_data,
    imm:            id_imm,
    pc:             id_pc,
    pc_plus4:       id_pc_plus4
  };

  // A load in EX whose result the instruction in ID needs; x0 is never a hazard.
  assign load_use = ex_q.valid && (ex_q.wb_src == WB_MEM) && (ex_q.rd != 5'd0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // A flush kills the instruction in ID, so there is nothing left to stall for.
  assign stall_if_id = mem_hold | (load_use & ~ex_flush);

  assign load_bubble = ex_flush | load_use | ~id_valid;

  always_comb begin
    // NOTE: default assignment first so every path drives ex_d and no latch is inferred.
    ex_d = ex_q;
    if (!mem_hold) begin
      ex_d = load_bubble ? stage_t'('0) : id_bundle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all sequential state; the whole bundle resets
      // because a bubble must be all-zero, not just ex_valid=0.
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid          = ex_q.valid;
  assign ex_B_J            = ex_q.b_j;
  assign ex_memwrite_en    = ex_q.memwrite_en;
  assign ex_regwrite_en    = ex_q.regwrite_en;
  assign ex_alu_op         = ex_q.alu_op;
  assign ex_data_size      = ex_q.data_size;
  assign ex_extension_type = ex_q.extension_type;
  assign ex_wb_src         = ex_q.wb_src;
  assign ex_alu_src        = ex_q.alu_src;
  assign ex_op1_src        = ex_q.op1_src;
  assign ex_rs1            = ex_q.rs1;
  assign ex_rs2            = ex_q.rs2;
  assign ex_rd             = ex_q.rd;
  assign ex_rs1_data       = ex_q.rs1_data;
  assign ex_rs2_data       = ex_q.rs2_data;
  assign ex_imm            = ex_q.imm;
  assign ex_pc             = ex_q.pc;
  assign ex_pc_plus4       = ex_q.pc_plus4;

`ifdef ID_EX_PERF_CNT_EN
  logic [PERF_W-1:0] bubble_q;
  logic [PERF_W-1:0] flush_q;

  // Counters wrap naturally at 2^PERF_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else if (!mem_hold) begin
      if (ex_flush) begin
        flush_q <= flush_q + PERF_W'(1);
      end else if (load_use) begin
        bubble_q <= bubble_q + PERF_W'(1);
      end
    end
  end

  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: reference model plus expected-result queue.
`timescale 1ns/1ps

module tb_id_ex_stage_reg;

  localparam int XLEN   = 32;
  localparam int PERF_W = 32;

  typedef struct packed {
    logic        valid;
    logic [2:0]  bj;
    logic        memwrite_en;
    logic        regwrite_en;
    logic [3:0]  alu_op;
    logic [1:0]  data_size;
    logic        ext;
    logic [1:0]  wb_src;
    logic        alu_src;
    logic        op1_src;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } instr_t;

  typedef struct packed {
    logic [191:0] ex;
    logic [31:0]  bcnt;
    logic [31:0]  fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            id_valid, id_memwrite_en, id_regwrite_en, id_extension_type;
  logic            id_alu_src, id_op1_src, id_use_rs1, id_use_rs2;
  logic [2:0]      id_B_J;
  logic [3:0]      id_alu_op;
  logic [1:0]      id_data_size, id_wb_src;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc, id_pc_plus4;
  logic            ex_flush, mem_hold;

  logic            ex_valid, ex_memwrite_en, ex_regwrite_en, ex_extension_type;
  logic            ex_alu_src, ex_op1_src;
  logic [2:0]      ex_B_J;
  logic [3:0]      ex_alu_op;
  logic [1:0]      ex_data_size, ex_wb_src;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_pc_plus4;
  logic            stall_if_id;
  logic [PERF_W-1:0] bubble_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  instr_t     m;
  logic [31:0] m_bcnt = '0;
  logic [31:0] m_fcnt = '0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_B_J(id_B_J), .id_memwrite_en(id_memwrite_en),
    .id_regwrite_en(id_regwrite_en), .id_alu_op(id_alu_op), .id_data_size(id_data_size),
    .id_extension_type(id_extension_type), .id_wb_src(id_wb_src), .id_alu_src(id_alu_src),
    .id_op1_src(id_op1_src), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .ex_flush(ex_flush), .mem_hold(mem_hold),
    .ex_valid(ex_valid), .ex_B_J(ex_B_J), .ex_memwrite_en(ex_memwrite_en),
    .ex_regwrite_en(ex_regwrite_en), .ex_alu_op(ex_alu_op), .ex_data_size(ex_data_size),
    .ex_extension_type(ex_extension_type), .ex_wb_src(ex_wb_src), .ex_alu_src(ex_alu_src),
    .ex_op1_src(ex_op1_src), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4),
    .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  wire [191:0] ex_all = {ex_valid, ex_B_J, ex_memwrite_en, ex_regwrite_en, ex_alu_op,
                         ex_data_size, ex_extension_type, ex_wb_src, ex_alu_src, ex_op1_src,
                         ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
                         ex_pc_plus4};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [191:0] pack(input instr_t i);
    return {i.valid, i.bj, i.memwrite_en, i.regwrite_en, i.alu_op, i.data_size, i.ext,
            i.wb_src, i.alu_src, i.op1_src, i.rs1, i.rs2, i.rd, i.rs1_data, i.rs2_data,
            i.imm, i.pc, i.pc_plus4};
  endfunction

  function automatic instr_t base(input logic [31:0] pc);
    instr_t i = '0;
    i.valid    = 1'b1;
    i.rs1_data = $urandom;
    i.rs2_data = $urandom;
    i.pc       = pc;
    i.pc_plus4 = pc + 32'd4;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc);
    instr_t i = base(pc);
    i.regwrite_en = 1'b1; i.data_size = 2'b10; i.wb_src = 2'b01; i.alu_src = 1'b1;
    i.use_rs1 = 1'b1; i.rs1 = rs1; i.rd = rd; i.imm = 32'h8;
    return i;
  endfunction

  function automatic instr_t mk_add(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [31:0] pc);
    instr_t i = base(pc);
    i.regwrite_en = 1'b1; i.data_size = 2'b11; i.wb_src = 2'b00;
    i.use_rs1 = 1'b1; i.use_rs2 = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t mk_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [31:0] imm, input logic [31:0] pc);
    instr_t i = base(pc);
    i.regwrite_en = 1'b1; i.data_size = 2'b11; i.alu_src = 1'b1;
    i.use_rs1 = 1'b1; i.rs1 = rs1; i.rd = rd; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t mk_lui(input logic [4:0] rd, input logic [31:0] pc);
    instr_t i = base(pc);
    i.regwrite_en = 1'b1; i.data_size = 2'b11; i.wb_src = 2'b10; i.rd = rd;
    i.imm = 32'h1234_5000;
    return i;
  endfunction

  task automatic drive(input instr_t i, input logic fl, input logic hd);
    id_valid = i.valid; id_B_J = i.bj; id_memwrite_en = i.memwrite_en;
    id_regwrite_en = i.regwrite_en; id_alu_op = i.alu_op; id_data_size = i.data_size;
    id_extension_type = i.ext; id_wb_src = i.wb_src; id_alu_src = i.alu_src;
    id_op1_src = i.op1_src; id_use_rs1 = i.use_rs1; id_use_rs2 = i.use_rs2;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_rs1_data = i.rs1_data; id_rs2_data = i.rs2_data; id_imm = i.imm;
    id_pc = i.pc; id_pc_plus4 = i.pc_plus4;
    ex_flush = fl; mem_hold = hd;
  endtask

  // One clock: drive on the falling edge, check stall, predict, then compare after the edge.
  task automatic step(input string tag, input instr_t i, input logic fl, input logic hd);
    logic lu;
    exp_t e;
    @(negedge clk);
    drive(i, fl, hd);
    #1;
    lu = m.valid && (m.wb_src == 2'b01) && (m.rd != 5'd0) && i.valid &&
         ((i.use_rs1 && (i.rs1 == m.rd)) || (i.use_rs2 && (i.rs2 == m.rd)));
    check({tag, ".stall"}, 256'(stall_if_id), 256'(hd | (lu & ~fl)));
    if (!hd) begin
`ifdef ID_EX_PERF_CNT_EN
      if (fl) m_fcnt = m_fcnt + 32'd1;
      else if (lu) m_bcnt = m_bcnt + 32'd1;
`endif
      if (fl || lu || !i.valid) m = '0;
      else m = i;
    end
    e.ex = pack(m); e.bcnt = m_bcnt; e.fcnt = m_fcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 256'(1), 256'(0));
    end else begin
      e = sb.pop_front();
      check({tag, ".ex"}, 256'(ex_all), 256'(e.ex));
      check({tag, ".bubble_cnt"}, 256'(bubble_cnt), 256'(e.bcnt));
      check({tag, ".flush_cnt"}, 256'(flush_cnt), 256'(e.fcnt));
    end
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".ex"}, 256'(ex_all), 256'(0));
    check({tag, ".bubble_cnt"}, 256'(bubble_cnt), 256'(0));
    check({tag, ".flush_cnt"}, 256'(flush_cnt), 256'(0));
    drive('0, 1'b0, 1'b0);
    m = '0; m_bcnt = '0; m_fcnt = '0;
    sb.delete();
    #1;
    rst_n = 1'b1;
  endtask

  instr_t lw5, add6, t;

  initial begin
    m = '0;
    drive('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.ex", 256'(ex_all), 256'(0));
    check("reset.stall", 256'(stall_if_id), 256'(0));
    check("reset.cnt", 256'({bubble_cnt, flush_cnt}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through of ADDI x3, x0, 0x10 at pc 0x100
    step("addi", mk_addi(5'd3, 5'd0, 32'h10, 32'h100), 1'b0, 1'b0);
    check("addi.valid", 256'(ex_valid), 256'(1));
    check("addi.alu_op", 256'(ex_alu_op), 256'(4'b0000));
    check("addi.imm", 256'(ex_imm), 256'(32'h10));
    check("addi.pc", 256'(ex_pc), 256'(32'h100));
    check("addi.rd", 256'(ex_rd), 256'(5'd3));

    // Reset mid-operation with ADD rd=5 in EX
    step("add5", mk_add(5'd5, 5'd1, 5'd2, 32'h104), 1'b0, 1'b0);
    check("add5.valid", 256'(ex_valid), 256'(1));
    reset_pulse("rst_mid");

    // Load-use: LW x5 then ADD x6,x5,x1 stalls one cycle, then enters EX
    lw5  = mk_lw(5'd5, 5'd2, 32'h200);
    add6 = mk_add(5'd6, 5'd5, 5'd1, 32'h204);
    step("lu.lw", lw5, 1'b0, 1'b0);
    step("lu.add1", add6, 1'b0, 1'b0);
    check("lu.bubble_valid", 256'(ex_valid), 256'(0));
    check("lu.bubble_regwr", 256'(ex_regwrite_en), 256'(0));
    step("lu.add2", add6, 1'b0, 1'b0);
    check("lu.add_rd", 256'(ex_rd), 256'(5'd6));
`ifdef ID_EX_PERF_CNT_EN
    check("lu.bubble_cnt1", 256'(bubble_cnt), 256'(1));
`endif

    // Hazard on x0 is never detected; instructions that read no register never stall
    step("x0.lw", mk_lw(5'd0, 5'd2, 32'h300), 1'b0, 1'b0);
    step("x0.add", mk_add(5'd7, 5'd0, 5'd0, 32'h304), 1'b0, 1'b0);
    step("nouse.lw", mk_lw(5'd5, 5'd2, 32'h308), 1'b0, 1'b0);
    step("nouse.lui", mk_lui(5'd7, 32'h30c), 1'b0, 1'b0);
    step("rs2.lw", mk_lw(5'd9, 5'd2, 32'h310), 1'b0, 1'b0);
    step("rs2.add", mk_add(5'd4, 5'd1, 5'd9, 32'h314), 1'b0, 1'b0);

    // Flush in the same cycle as a load-use hazard
    reset_pulse("rst_fl");
    step("fl.lw", lw5, 1'b0, 1'b0);
    step("fl.add", add6, 1'b1, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    check("fl.cnts", 256'({bubble_cnt, flush_cnt}), 256'({32'd0, 32'd1}));
`endif

    // Hold beats flush for two cycles, then the flush lands as a bubble
    t = mk_addi(5'd8, 5'd1, 32'h44, 32'h400);
    step("hf.addi", t, 1'b0, 1'b0);
    step("hf.hold1", mk_add(5'd9, 5'd8, 5'd1, 32'h404), 1'b1, 1'b1);
    step("hf.hold2", mk_add(5'd9, 5'd8, 5'd1, 32'h404), 1'b1, 1'b1);
    check("hf.kept_pc", 256'(ex_pc), 256'(32'h400));
    step("hf.release", mk_add(5'd9, 5'd8, 5'd1, 32'h404), 1'b1, 1'b0);

    // Reset while held
    step("rh.lw", lw5, 1'b0, 1'b0);
    step("rh.hold", add6, 1'b0, 1'b1);
    reset_pulse("rst_hold");

    // Random mix over a small register range to provoke hazards, flushes and holds
    for (int k = 0; k < 60; k++) begin
      logic [4:0] ra, rb, rc;
      ra = 5'($urandom_range(0, 3));
      rb = 5'($urandom_range(0, 3));
      rc = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0, 1:    t = mk_lw(ra, rb, 32'h1000 + 32'(k * 4));
        2:       t = mk_add(ra, rb, rc, 32'h1000 + 32'(k * 4));
        3:       t = mk_lui(ra, 32'h1000 + 32'(k * 4));
        default: begin t = mk_addi(ra, rb, 32'(k), 32'h1000 + 32'(k * 4)); t.valid = ($urandom_range(0, 1) == 1); end
      endcase
      t.alu_op = 4'($urandom);
      t.bj     = 3'($urandom);
      step("rnd", t, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
